// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} WIDTH+1 cycles after acceptance; busy_o feeds the stall request.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [1:0]           state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     dq_q;
  logic [WIDTH-1:0]     dvs_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 sgn1_q;
  logic                 sgn2_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 busy_q;

  logic [WIDTH:0]       partial;
  logic [WIDTH-1:0]     diff;
  logic                 take;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     dq_d;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last_step;

  // dq_q holds the dividend on acceptance; each step shifts a dividend bit out
  // of the top and a quotient bit into the bottom, so it ends as the quotient.
  always_comb begin
    partial   = {rem_q, dq_q[WIDTH-1]};
    diff      = partial[WIDTH-1:0] - dvs_q;
    take      = (partial >= {1'b0, dvs_q});
    rem_d     = take ? diff : partial[WIDTH-1:0];
    dq_d      = {dq_q[WIDTH-2:0], take};
    quo_fix   = (sgn1_q ^ sgn2_q) ? -dq_d : dq_d;
    rem_fix   = sgn1_q ? -rem_d : rem_d;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          busy_q   <= 1'b0;
          if (start_i && !annul_i) begin
            // Sign bits are only kept in signed mode, so unsigned needs no fix-up.
            sgn1_q <= signed_div_i & opdata1_i[WIDTH-1];
            sgn2_q <= signed_div_i & opdata2_i[WIDTH-1];
            dq_q   <= (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            dvs_q  <= (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state_q <= (opdata2_i == '0) ? S_BY_ZERO : S_ON;
          end
        end
        S_BY_ZERO: begin
          busy_q <= 1'b0;
          if (annul_i) begin
            state_q <= S_FREE;
          end else begin
            state_q  <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q <= S_FREE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
              state_q  <= S_END;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              result_q <= {rem_fix, quo_fix};
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus directed corner sequences at WIDTH=32,
// and a WIDTH=8 instance for the short-latency / held-result case.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [1:0]  state_o;

  logic        sgn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        start8;
  logic        annul8;
  logic [15:0] result8;
  logic        ready8;
  logic        busy8;
  logic [1:0]  state8;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t        vecs[13];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .state_o(state_o)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8),
    .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8),
    .result_o(result8), .ready_o(ready8), .busy_o(busy8), .state_o(state8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Full operation on the 32-bit DUT: accept, scramble operands, wait for ready,
  // compare against the scoreboard, hold one cycle, drop start and check FREE.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int          lat;
    int          bad_busy;
    logic [63:0] got;
    logic [63:0] want;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    lat      = 1;
    bad_busy = 0;
    while (!ready_o && lat < 100) begin
      if (busy_o !== 1'b1) bad_busy++;
      @(negedge clk);
      lat++;
    end
    got  = result_o;
    want = exp_q.pop_front();
    check({name, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    check({name, "_busy_window"}, 64'(bad_busy), 64'd0);
    check({name, "_busy_end"}, 64'(busy_o), 64'd0);
    check({name, "_result"}, got, want);
    @(negedge clk);
    check({name, "_hold"}, {63'd0, ready_o} ^ result_o, {63'd0, 1'b1} ^ want);
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_free"}, {result_o[61:0], ready_o, busy_o}, 64'd0);
    check({name, "_state_free"}, 64'(state_o), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[8]  = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

    rst = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0; start_i = 1'b0; annul_i = 1'b0;
    sgn8 = 1'b0; a8 = '0; b8 = '0; start8 = 1'b0; annul8 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("reset_state", 64'(state_o), 64'd0);
    check("reset_w8", {46'd0, result8, ready8, busy8}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q});

    // start and annul together in FREE: annul wins
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    check("annul_free_state", 64'(state_o), 64'd0);
    check("annul_free_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    // annul in ON at t+10, new start at t+12
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd123456; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (9) @(negedge clk);
    @(negedge clk);
    check("annul_on_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_on_busy_after", 64'(busy_o), 64'd0);
    check("annul_on_ready", 64'(ready_o), 64'd0);
    check("annul_on_state", 64'(state_o), 64'd0);
    run_op("after_annul", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100});

    // annul in BY_ZERO
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    check("byzero_busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("byzero_annul", {62'd0, ready_o, busy_o}, 64'd0);
    check("byzero_annul_state", 64'(state_o), 64'd0);

    // WIDTH=8: 200 / 3, result held through END, annul ignored in END
    @(negedge clk);
    sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    exp_q.push_back({48'd0, 8'd2, 8'd66});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin a8 = 8'($urandom); b8 = 8'($urandom); end
    end while (!ready8 && lat < 50);
    check("w8_latency", 64'(lat), 64'd9);
    check("w8_result", {48'd0, result8}, exp_q.pop_front());
    held = result8;
    for (int h = 0; h < 5; h++) begin
      annul8 = (h == 1);
      @(negedge clk);
      check($sformatf("w8_hold%0d", h), {47'd0, ready8, result8}, {47'd0, 1'b1, held});
    end
    annul8 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("w8_free", {46'd0, result8, ready8, busy8}, 64'd0);

    // asynchronous reset in the middle of ON
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10; start_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy_o), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("rst_mid_state", 64'(state_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_reset", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

    // random operands against the reference model
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", i), rs, ra, rb, ref32(rs, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the OpenMIPS execute stage, serving DIV/DIVU. It accepts one operand pair per operation and computes quotient and remainder by radix-2 restoring division, one bit per cycle. While busy it supplies the source for `stallreq_from_ex` to `ctrl`, and its result feeds the HI/LO write path. It supports signed and unsigned modes, divide-by-zero, and annulment of an operation in flight when the pipeline is flushed.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits; legal range 4..64.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `signed_div_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
- `opdata1_i` in WIDTH: dividend; sampled at acceptance.
- `opdata2_i` in WIDTH: divisor; sampled at acceptance.
- `start_i` in 1: operation request; level-held by the execute stage until `ready_o` is seen.
- `annul_i` in 1: abort the current or requested operation.
- `result_o` out 2*WIDTH: {remainder, quotient}; valid only while `ready_o` = 1, zero otherwise.
- `ready_o` out 1: result valid.
- `busy_o` out 1: operation in progress; drives `stallreq_from_ex`.

## Operation
- State machine with four states: FREE, BY_ZERO, ON, END. All outputs are registered or decoded from state.
- FREE:
  - `start_i`=1 and `annul_i`=0 is acceptance; operands and mode are latched on that edge.
  - If divisor = 0, next state is BY_ZERO.
  - Otherwise next state is ON with iteration counter = 0.
  - Signed mode latches the magnitudes of both operands plus the two sign bits.
  - `start_i` and `annul_i` high together: annul wins and the block stays in FREE.
- ON:
  - Each cycle performs one restoring step: shift the partial remainder left by 1 and bring in the next dividend bit.
  - If partial remainder >= divisor magnitude, subtract it and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - Counter increments each step; after WIDTH steps the next state is END.
- BY_ZERO: one cycle, then END with quotient = 0 and remainder = 0.
- END (result registered on entry):
  - Sign fix-up in signed mode: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 wraps: quotient = 2^(WIDTH-1) pattern, remainder = 0.
  - Unsigned mode applies no fix-up.
- Leaving END: the block stays in END while `start_i`=1 and returns to FREE on the first cycle `start_i`=0. Back-to-back operations therefore need `start_i` low for at least 1 cycle.
- `annul_i`=1 in ON or BY_ZERO: next state is FREE and no result is produced.
- `annul_i` in END is ignored.
- Operand changes after acceptance are ignored.
- Reset (asynchronous, mid-operation included) forces FREE, clears the counter, and sets `result_o`=0, `ready_o`=0, `busy_o`=0.

## Timing
- Let acceptance occur on the rising edge closing cycle t.
- Normal operation: ON occupies cycles t+1..t+WIDTH. END, with `ready_o`=1 and `result_o` valid, starts at cycle t+WIDTH+1, giving a latency of WIDTH+1 cycles.
- Divide-by-zero: BY_ZERO at t+1, END at t+2.
- `busy_o`:
  - 1 in BY_ZERO and ON.
  - 0 in FREE and END.
  - 0 in cycle t itself; the combined stall request in cycle t comes from `ctrl`'s decode of `start_i`.
- After annul in ON at cycle a: FREE at a+1 with `busy_o`=0.
- After `start_i` falls at cycle d while in END: FREE at d+1 with `ready_o`=0 and `result_o`=0.
- Throughput: at most one operation per WIDTH+3 cycles.

## Test plan
- WIDTH=32, unsigned, 100 / 7, start at t: `busy_o` high t+1..t+32; at t+33 `ready_o`=1 and `result_o`={2, 14}. Dropping `start_i` at t+34 gives FREE at t+35.
- WIDTH=32, signed, -7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2: quotient 0xFFFFFFFD, remainder 1.
- Divisor 0, either mode: `ready_o`=1 at t+2 with `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Start, then `annul_i` pulse at t+10: `busy_o`=0 at t+11 and `ready_o` never rises. A new start at t+12 completes correctly (1000 / 10 gives {0, 100}).
- WIDTH=8, unsigned, 200 / 3: `ready_o` at t+9 with `result_o`={2, 66}. `start_i` held high through END keeps the result stable for 5 cycles.
- Drive `rst` low asynchronously mid-ON (between edges): outputs clear immediately. After release, 50 / 5 completes with {0, 10}.
